// File: rtl/joy_pkg.sv
// Shared constants, repeat FSM state type and counter sizing for the
// joystick conditioner.
//
// Contents:
//   JOY_RIGHT/LEFT/DOWN/UP : bit positions of the directions in a pad word
//   rpt_state_t            : auto-repeat FSM states
//   cnt_width()            : bits needed to hold a count up to max_val
package joy_pkg;

   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_t;

   function automatic int cnt_width(input int max_val);
      if (max_val < 2) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit debouncer: output follows the raw input only after the raw
// value has differed from it for DB_CYCLES consecutive cycles.
//
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_raw          : raw button bit
//   o_db           : debounced level
// DB_CYCLES = 0 passes i_raw straight through; the top's level register
// then provides the single cycle of latency.
module joy_debounce
   import joy_pkg::*;
#(
   parameter int DB_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_db
);

   generate
      if (DB_CYCLES == 0) begin : g_bypass
         logic w_unused;
         assign w_unused = i_clk ^ i_reset;
         assign o_db     = i_raw;
      end else begin : g_filter
         localparam int CW = cnt_width(DB_CYCLES);

         logic [CW-1:0] r_cnt;
         logic          r_db;

         // r_cnt counts cycles of disagreement already seen; the
         // DB_CYCLES-th one commits the new value.
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_cnt <= '0;
               r_db  <= 1'b0;
            end else if (i_raw == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
               r_db  <= i_raw;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign o_db = r_db;
      end
   endgenerate

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner: debounces every pad, muxes the selected pad,
// derives press/release pulses and direction auto-repeat pulses.
//
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   joy_in      : NUM_PADS packed pad words, pad p at [p*NUM_BTN +: NUM_BTN]
//   pad_sel     : pad driving the outputs (out-of-range selects pad 0)
//   lock        : forces all outputs to 0, debouncers keep running
//   btn_level   : debounced level of the selected pad
//   btn_press   : one-cycle pulse on level rise
//   btn_release : one-cycle pulse on level fall
//   btn_repeat  : direction pulses (press plus auto-repeat)
// Optional feature macro: JOY_AUTOREPEAT_EN (repeat FSM); when undefined
// btn_repeat mirrors btn_press[3:0].
module joy_conditioner
   import joy_pkg::*;
#(
   parameter int NUM_PADS   = 2,
   parameter int NUM_BTN    = 16,
   parameter int DB_CYCLES  = 1024,
   parameter int RPT_DELAY  = 12_000_000,
   parameter int RPT_PERIOD = 3_000_000,
   localparam int SEL_W     = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PADS*NUM_BTN-1:0] joy_in,
   input  logic [SEL_W-1:0]            pad_sel,
   input  logic                        lock,
   output logic [NUM_BTN-1:0]          btn_level,
   output logic [NUM_BTN-1:0]          btn_press,
   output logic [NUM_BTN-1:0]          btn_release,
   output logic [3:0]                  btn_repeat
);

   logic [NUM_PADS*NUM_BTN-1:0] w_db;
   logic [NUM_BTN-1:0]          w_mux;
   logic [NUM_BTN-1:0]          w_level_nxt;
   logic [NUM_BTN-1:0]          w_press_nxt;
   logic [NUM_BTN-1:0]          w_rel_nxt;
   logic [3:0]                  w_rpt_nxt;
   logic                        w_switch;
   logic                        w_unlock;
   logic                        w_quiet;

   logic [SEL_W-1:0]            r_sel;
   logic                        r_lock;
   logic [NUM_BTN-1:0]          r_level;
   logic [NUM_BTN-1:0]          r_press;
   logic [NUM_BTN-1:0]          r_release;
   logic [3:0]                  r_rpt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PADS * NUM_BTN; gi++) begin : g_db
         joy_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_db (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (joy_in[gi]),
            .o_db    (w_db[gi])
         );
      end
   endgenerate

   // Pad 0 is the default so out-of-range selects fall back to it.
   always_comb begin
      w_mux = w_db[NUM_BTN-1:0];
      for (int p = 1; p < NUM_PADS; p++) begin
         if (pad_sel == SEL_W'(p)) begin
            w_mux = w_db[p*NUM_BTN +: NUM_BTN];
         end
      end
   end

   // r_level doubles as the "previous level" for edge detection.
   // Pulses are masked on a pad switch, while locked and on the first
   // unlocked cycle, so buttons already held never fire a press.
   assign w_switch    = (pad_sel != r_sel);
   assign w_unlock    = r_lock & ~lock;
   assign w_quiet     = w_switch | lock | w_unlock;
   assign w_level_nxt = lock ? '0 : w_mux;
   assign w_press_nxt = w_quiet ? '0 : (w_level_nxt & ~r_level);
   assign w_rel_nxt   = w_quiet ? '0 : (~w_level_nxt & r_level);

`ifdef JOY_AUTOREPEAT_EN
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY
                                                     : RPT_PERIOD;
   localparam int RPT_W   = cnt_width(RPT_MAX);

   rpt_state_t       r_state;
   rpt_state_t       w_state_nxt;
   logic [RPT_W-1:0] r_cnt;
   logic [RPT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_dir;
   logic [1:0]       w_dir_nxt;
   logic [1:0]       w_low;
   logic             w_any;
   logic             w_dir_rel;
   logic             w_expire;
   logic             w_pulse;

   assign w_any     = |w_press_nxt[3:0];
   assign w_dir_rel = w_rel_nxt[r_dir];
   assign w_expire  = (r_state != IDLE) && (r_cnt == RPT_W'(1));

   // Lowest pressed direction wins when several rise together.
   always_comb begin
      w_low = 2'(JOY_RIGHT);
      priority case (1'b1)
         w_press_nxt[JOY_RIGHT]: w_low = 2'(JOY_RIGHT);
         w_press_nxt[JOY_LEFT]:  w_low = 2'(JOY_LEFT);
         w_press_nxt[JOY_DOWN]:  w_low = 2'(JOY_DOWN);
         w_press_nxt[JOY_UP]:    w_low = 2'(JOY_UP);
         default:                w_low = 2'(JOY_RIGHT);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_dir   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   // A new press retargets ahead of expiry; a release of the tracked
   // direction stops repeating even if others remain held.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      if (w_quiet) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else if (w_any) begin
         w_state_nxt = DELAY;
         w_cnt_nxt   = RPT_W'(RPT_DELAY);
         w_dir_nxt   = w_low;
      end else if (r_state != IDLE) begin
         if (w_dir_rel) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end else if (w_expire) begin
            w_state_nxt = REPEAT;
            w_cnt_nxt   = RPT_W'(RPT_PERIOD);
         end else begin
            w_cnt_nxt   = r_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      w_pulse   = ~w_quiet & (w_any | (w_expire & ~w_dir_rel));
      w_rpt_nxt = 4'b0000;
      if (w_pulse) begin
         w_rpt_nxt = 4'b0001 << w_dir_nxt;
      end
   end
`else
   assign w_rpt_nxt = w_press_nxt[3:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel     <= '0;
         r_lock    <= 1'b0;
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_rpt     <= '0;
      end else begin
         r_sel     <= pad_sel;
         r_lock    <= lock;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_rel_nxt;
         r_rpt     <= w_rpt_nxt;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign btn_repeat  = r_rpt;

endmodule

// File: doc/joy_conditioner.md
# joy_conditioner

Parametrised controller-input conditioner between `hps_io` joystick words and core game logic. It replaces direct wiring of raw joystick bits with debounced levels, single-cycle press/release pulses, an active-pad multiplexer (e.g. two human players selected by side to move) and cursor auto-repeat for held directions. It runs entirely in the core's system clock domain and feeds the game top module's `input_*` ports.

## Interface
Parameters:
- `NUM_PADS`, 2: joysticks accepted, 1..4.
- `NUM_BTN`, 16: bits per joystick word, >= 4; bits 3:0 are right/left/down/up.
- `DB_CYCLES`, 1024: consecutive cycles a changed raw bit must hold before the debounced level follows; 0 = bypass.
- `RPT_DELAY`, 12_000_000: cycles from initial direction press to first repeat, >= 1.
- `RPT_PERIOD`, 3_000_000: cycles between subsequent repeats, >= 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `joy_in` in NUM_PADS*NUM_BTN: pad p at `[p*NUM_BTN +: NUM_BTN]`, active-high.
- `pad_sel` in max(1,$clog2(NUM_PADS)): pad driving outputs; values >= NUM_PADS select pad 0.
- `lock` in 1: suppress all outputs (OSD open, AI thinking).
- `btn_level` out NUM_BTN: debounced level of the selected pad.
- `btn_press` out NUM_BTN: one-cycle pulse on a 0->1 `btn_level` transition.
- `btn_release` out NUM_BTN: one-cycle pulse on a 1->0 `btn_level` transition.
- `btn_repeat` out 4: direction pulses (initial press plus auto-repeat).

## Operation
- Debounce per pad per bit. Counter clears while raw == debounced and increments while raw != debounced; when it reaches DB_CYCLES, debounced takes raw and the counter clears. With DB_CYCLES = 0, debounced = raw delayed by one register.
- Mux selects the pad's debounced vector into `btn_level`. `prev` register holds the last `btn_level`: press = level & ~prev, release = ~level & prev.
- Pad switch: in the cycle `pad_sel` differs from its registered copy, `btn_level` shows the new pad, `prev` loads the same value, and press/release/repeat are 0. Buttons already held on the new pad produce no press. Repeat FSM goes to IDLE.
- Lock: while `lock` = 1, `btn_level`, pulses and repeat are 0, and debouncers keep running. On the first cycle after deassert, `prev` loads the current level, so held buttons do not fire.
- Repeat FSM (single tracked direction `dir`):
  - IDLE: on any press[3:0], set dir to the lowest pressed index, pulse `btn_repeat[dir]`, load counter with RPT_DELAY, go to DELAY.
  - DELAY/REPEAT: counter decrements each cycle. At 1: pulse, reload with RPT_PERIOD, go to REPEAT.
  - A new press of any direction retargets: pulse, reload RPT_DELAY, go to DELAY (retarget wins over a same-cycle expiry).
  - Release of dir: go to IDLE, no pulse, even if other directions are still held.
- Simultaneous press of several directions: only the lowest index repeats. All of them still appear on `btn_press`.

## Timing
- Reset: all outputs 0, debounced vectors 0, counters 0, FSM IDLE, `prev` 0, `pad_sel` copy 0. Buttons held through reset are re-debounced and yield a press.
- Latency from raw change to `btn_level`: DB_CYCLES+1 cycles (1 cycle when bypassed). `btn_press` and the first `btn_repeat` are in the same cycle as the `btn_level` rise.
- Repeat pulses while a direction is held: t0, t0+RPT_DELAY, then every RPT_PERIOD cycles.
- All outputs are registered. There is no handshake; consumers sample pulses on the single cycle they are high.

## Configuration
- `JOY_AUTOREPEAT_EN` defined: repeat FSM and counter present, behaviour as above.
- Not defined: `btn_repeat` = `btn_press[3:0]`, and no FSM or repeat counter is synthesised.

## Structure
- Package `joy_pkg`:
  - constants `JOY_RIGHT`=0, `JOY_LEFT`=1, `JOY_DOWN`=2, `JOY_UP`=3;
  - enum `rpt_state_t` {IDLE, DELAY, REPEAT};
  - counter-width function.
- Sub-module `joy_debounce`: one bit, one counter, parameter DB_CYCLES. Instantiated NUM_PADS*NUM_BTN times in a generate loop. Mux, edge detection and FSM live in the top.

## Test plan
Bench parameters: DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, NUM_PADS=2.
- Pad 0 bit 4 set high at cycle 0 -> `btn_level[4]` and `btn_press[4]` high at cycle 5, press for 1 cycle only. A 3-cycle glitch on bit 5 produces no output.
- Hold up (bit 3) on pad 0 from level rise t0 -> `btn_repeat[3]` at t0, t0+10, t0+13, t0+16. Release at t0+14 -> no further pulses, `btn_release[3]` at the release level-fall cycle.
- Right and left rise together -> `btn_press`=0x3, repeat tracks bit 0 only. Pressing down at t0+5 -> `btn_repeat[2]` pulse, next at +10.
- Pad 1 holding bit 4, switch `pad_sel` 0->1 -> `btn_level[4]`=1 with no press/release that cycle or later until re-pressed.
- `lock`=1 while bit 4 rises on the selected pad -> outputs 0. Deassert -> `btn_level[4]`=1, no `btn_press`.
- Assert `reset` mid-REPEAT with direction held -> next cycle all outputs 0, then press re-emerges 5 cycles after reset release. Without `JOY_AUTOREPEAT_EN`, the same hold gives exactly one `btn_repeat` pulse.
